// File: rtl/qword_packer_pkg.sv
// -----------------------------------------------------------------------------
// qword_packer_pkg
// Shared constants and helpers for the byte-to-qword packer and the hex-dump
// stage that unpacks the same words.
//   BYTES_PER_WORD / QWORD_W : word geometry
//   ST_FILL / ST_PUSH        : 1-bit FSM encoding of the packer
//   DEFAULT_PAD_BYTE         : fill value for unused lanes of a flushed word
//   lane_insert()            : place byte number k of a group into its lane
// -----------------------------------------------------------------------------
package qword_packer_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int QWORD_W        = 64;

  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'h00;

  typedef logic [0:0] state_t;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_PUSH = 1'b1;

  // Byte k of a group goes to bits [63-8k -: 8] when msb_first, else [8k +: 8].
  // The dump stage uses the same mapping to pull bytes back out in order.
  function automatic logic [QWORD_W-1:0] lane_insert(
    input logic [QWORD_W-1:0] word,
    input logic [7:0]         byte_in,
    input logic [2:0]         idx,
    input logic               msb_first
  );
    logic [QWORD_W-1:0] w;
    logic [2:0]         lane;
    w    = word;
    lane = msb_first ? (3'd7 - idx) : idx;
    w[{lane, 3'b000} +: 8] = byte_in;
    return w;
  endfunction

endpackage

// File: rtl/qword_packer_if.sv
// -----------------------------------------------------------------------------
// qword_packer_if
// Bundles the packer's byte-stream input, FIFO write port and status.
//   s_valid/s_data/s_last/s_ready : upstream byte handshake
//   fifo_full/fifo_we/fifo_data   : downstream 64-bit FIFO write port
//   fill_level/busy               : status
// modport slave  : seen by the packer
// modport master : seen by the environment driving/consuming the packer
// -----------------------------------------------------------------------------
interface qword_packer_if;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        fifo_full;
  logic        fifo_we;
  logic [63:0] fifo_data;
  logic [3:0]  fill_level;
  logic        busy;

  modport slave (
    input  s_valid, s_data, s_last, fifo_full,
    output s_ready, fifo_we, fifo_data, fill_level, busy
  );

  modport master (
    output s_valid, s_data, s_last, fifo_full,
    input  s_ready, fifo_we, fifo_data, fill_level, busy
  );

endinterface

// File: rtl/qword_packer.sv
// -----------------------------------------------------------------------------
// qword_packer
// Collects bytes from a valid/ready stream into 64-bit words and writes each
// completed word into a downstream FIFO, respecting its full flag.
//
// Ports:
//   clk  : single clock
//   rst  : asynchronous, active-high reset
//   bus  : qword_packer_if.slave (byte stream in, FIFO write out, status)
//
// Parameters:
//   MSB_FIRST : 1 = first byte of a group in [63:56], 0 = first byte in [7:0]
//   PAD_BYTE  : value of lanes not filled when a partial word is flushed
//
// Build option:
//   QWORD_PACKER_FLUSH_EN : when defined, a byte carrying s_last closes the
//   current word early (remaining lanes = PAD_BYTE). When undefined, s_last
//   is ignored and words close only after 8 bytes.
// -----------------------------------------------------------------------------
module qword_packer
  import qword_packer_pkg::*;
#(
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [7:0] PAD_BYTE  = DEFAULT_PAD_BYTE
) (
  input  logic             clk,
  input  logic             rst,
  qword_packer_if.slave    bus
);

  localparam logic [QWORD_W-1:0] PAD_WORD = {BYTES_PER_WORD{PAD_BYTE}};

  state_t             state_q, state_d;
  logic [3:0]         fill_q,  fill_d;
  logic [QWORD_W-1:0] word_q,  word_d;

  logic accept_s;
  logic write_s;
  logic close_s;

  // Ready is a pure decode of registered state, so s_valid never reaches
  // s_ready combinationally.
  assign accept_s = bus.s_valid & (state_q == ST_FILL);
  // The FIFO write follows fifo_full combinationally so a word is never
  // written while the FIFO reports full, yet is written the first free cycle.
  assign write_s  = (state_q == ST_PUSH) & ~bus.fifo_full;

`ifdef QWORD_PACKER_FLUSH_EN
  assign close_s = (fill_q == 4'd7) | bus.s_last;
`else
  // Frame boundaries do not close words in this build.
  logic unused_last_s;
  assign unused_last_s = bus.s_last;
  assign close_s       = (fill_q == 4'd7);
`endif

  // Next-state logic: gather bytes in FILL, hold the word in PUSH until written.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    word_d  = word_q;
    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          word_d  = lane_insert(word_q, bus.s_data, fill_q[2:0], MSB_FIRST);
          fill_d  = fill_q + 4'd1;
          state_d = close_s ? ST_PUSH : ST_FILL;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_PUSH: begin
        if (write_s) begin
          state_d = ST_FILL;
          fill_d  = 4'd0;
          word_d  = PAD_WORD;
        end else begin
          state_d = ST_PUSH;
        end
      end
      default: begin
        state_d = ST_FILL;
        fill_d  = 4'd0;
        word_d  = PAD_WORD;
      end
    endcase
  end

  // State, byte count and word register; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      fill_q  <= 4'd0;
      word_q  <= PAD_WORD;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
    end
  end

  assign bus.s_ready    = (state_q == ST_FILL);
  assign bus.busy       = (state_q == ST_PUSH);
  assign bus.fifo_we    = write_s;
  assign bus.fifo_data  = word_q;
  assign bus.fill_level = fill_q;

endmodule
